riscv_decode_issue: RTL

//  Decode/issue stage in front of the register file. Accepts instructions from fetch (valid/ready),

---
 rtl/riscv_decode_issue_pkg.sv | 63 ++++++
 rtl/riscv_imm_gen.sv | 22 ++
 rtl/riscv_decode_issue.sv | 117 +++++++++++
 3 files changed

// File: rtl/riscv_decode_issue_pkg.sv
// Shared decode constants for the decode/issue stage: opcodes, class encodings,
// immediate formats and the opcode -> control decode table.
package riscv_decode_issue_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] CLASS_LUI     = 4'd0;
    localparam logic [3:0] CLASS_AUIPC   = 4'd1;
    localparam logic [3:0] CLASS_JAL     = 4'd2;
    localparam logic [3:0] CLASS_JALR    = 4'd3;
    localparam logic [3:0] CLASS_BRANCH  = 4'd4;
    localparam logic [3:0] CLASS_LOAD    = 4'd5;
    localparam logic [3:0] CLASS_STORE   = 4'd6;
    localparam logic [3:0] CLASS_OP_IMM  = 4'd7;
    localparam logic [3:0] CLASS_OP      = 4'd8;
    localparam logic [3:0] CLASS_SYSTEM  = 4'd9;
    localparam logic [3:0] CLASS_ILLEGAL = 4'd15;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [3:0] cls;
        imm_fmt_e   fmt;
        logic       use_rs1;
        logic       use_rs2;
        logic       writes;
    } dec_t;

    function automatic dec_t decode_opcode(input logic [6:0] op);
        dec_t d;
        d.cls     = CLASS_ILLEGAL;
        d.fmt     = IMM_NONE;
        d.use_rs1 = 1'b0;
        d.use_rs2 = 1'b0;
        d.writes  = 1'b0;
        case (op)
            OPC_LUI:    begin d.cls = CLASS_LUI;    d.fmt = IMM_U; d.writes = 1'b1; end
            OPC_AUIPC:  begin d.cls = CLASS_AUIPC;  d.fmt = IMM_U; d.writes = 1'b1; end
            OPC_JAL:    begin d.cls = CLASS_JAL;    d.fmt = IMM_J; d.writes = 1'b1; end
            OPC_JALR:   begin d.cls = CLASS_JALR;   d.fmt = IMM_I; d.writes = 1'b1; d.use_rs1 = 1'b1; end
            OPC_BRANCH: begin d.cls = CLASS_BRANCH; d.fmt = IMM_B; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            OPC_LOAD:   begin d.cls = CLASS_LOAD;   d.fmt = IMM_I; d.writes = 1'b1; d.use_rs1 = 1'b1; end
            OPC_STORE:  begin d.cls = CLASS_STORE;  d.fmt = IMM_S; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            OPC_OP_IMM: begin d.cls = CLASS_OP_IMM; d.fmt = IMM_I; d.writes = 1'b1; d.use_rs1 = 1'b1; end
            OPC_OP:     begin d.cls = CLASS_OP;     d.writes = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            OPC_SYSTEM: begin d.cls = CLASS_SYSTEM; d.fmt = IMM_I; d.writes = 1'b1; end
            default:    ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RISC-V immediate extraction, sign-extended to 32 bits.
module riscv_imm_gen
    import riscv_decode_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/riscv_decode_issue.sv
// Decode/issue stage: decodes fetch instructions, stalls on RAW/WAW via a busy
// scoreboard, and registers operands into the ID/EX register.
module riscv_decode_issue
    import riscv_decode_issue_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_CLK,
    input  logic                      i_RSTn,
    input  logic                      i_IF_VALID,
    output logic                      o_IF_READY,
    input  logic [31:0]               i_IF_INSTR,
    input  logic [BUS_WIDTH-1:0]      i_IF_PC,
    output logic [REG_ADDR_WIDTH-1:0] o_RR1,
    output logic [REG_ADDR_WIDTH-1:0] o_RR2,
    input  logic [BUS_WIDTH-1:0]      i_DATA1,
    input  logic [BUS_WIDTH-1:0]      i_DATA2,
    input  logic                      i_WB_VALID,
    input  logic [REG_ADDR_WIDTH-1:0] i_WB_RD,
    input  logic                      i_FLUSH,
    output logic                      o_EX_VALID,
    input  logic                      i_EX_READY,
    output logic [BUS_WIDTH-1:0]      o_EX_PC,
    output logic [BUS_WIDTH-1:0]      o_EX_OP1,
    output logic [BUS_WIDTH-1:0]      o_EX_OP2,
    output logic [BUS_WIDTH-1:0]      o_EX_IMM,
    output logic [REG_ADDR_WIDTH-1:0] o_EX_RD,
    output logic [2:0]                o_EX_FUNCT3,
    output logic                      o_EX_F7B5,
    output logic [3:0]                o_EX_CLASS,
    output logic                      o_EX_WEN,
    output logic                      o_EX_ILLEGAL
);

    localparam int REG_DEPTH = 1 << REG_ADDR_WIDTH;

    logic [REG_DEPTH-1:0]      sb, sb_next, wb_mask, busy_vec;
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
    dec_t                      dec;
    logic [31:0]               imm;
    logic                      wen, illegal, hazard, accept;

    assign rs1   = i_IF_INSTR[19:15];
    assign rs2   = i_IF_INSTR[24:20];
    assign rd    = i_IF_INSTR[11:7];
    assign o_RR1 = rs1;
    assign o_RR2 = rs2;

    riscv_imm_gen u_imm_gen (
        .instr (i_IF_INSTR),
        .fmt   (dec.fmt),
        .imm   (imm)
    );

    // A same-cycle writeback is visible on i_DATA*, so it masks the busy bit.
    always_comb begin
        dec     = decode_opcode(i_IF_INSTR[6:0]);
        illegal = (dec.cls == CLASS_ILLEGAL);
        wen     = dec.writes & (rd != '0);
        wb_mask = '0;
        if (i_WB_VALID) wb_mask[i_WB_RD] = 1'b1;
        busy_vec    = sb & ~wb_mask;
        busy_vec[0] = 1'b0;
        hazard = (dec.use_rs1 & busy_vec[rs1])
               | (dec.use_rs2 & busy_vec[rs2])
               | (wen & busy_vec[rd]);
        accept = i_RSTn & i_IF_VALID & ~hazard & ~i_FLUSH & (~o_EX_VALID | i_EX_READY);
    end

    assign o_IF_READY = accept;

    // Clear on WB (and on squash of a held writer) first; a new issue's set wins.
    always_comb begin
        sb_next = sb & ~wb_mask;
        if (i_FLUSH && o_EX_VALID && o_EX_WEN) sb_next[o_EX_RD] = 1'b0;
        if (accept && wen) sb_next[rd] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            sb           <= '0;
            o_EX_VALID   <= 1'b0;
            o_EX_PC      <= '0;
            o_EX_OP1     <= '0;
            o_EX_OP2     <= '0;
            o_EX_IMM     <= '0;
            o_EX_RD      <= '0;
            o_EX_FUNCT3  <= '0;
            o_EX_F7B5    <= 1'b0;
            o_EX_CLASS   <= '0;
            o_EX_WEN     <= 1'b0;
            o_EX_ILLEGAL <= 1'b0;
        end else begin
            sb <= sb_next;
            if (i_FLUSH) begin
                o_EX_VALID <= 1'b0;
            end else if (accept) begin
                o_EX_VALID   <= 1'b1;
                o_EX_PC      <= i_IF_PC;
                o_EX_OP1     <= dec.use_rs1 ? i_DATA1 : '0;
                o_EX_OP2     <= dec.use_rs2 ? i_DATA2 : '0;
                o_EX_IMM     <= imm;
                o_EX_RD      <= rd;
                o_EX_FUNCT3  <= i_IF_INSTR[14:12];
                o_EX_F7B5    <= i_IF_INSTR[30];
                o_EX_CLASS   <= dec.cls;
                o_EX_WEN     <= wen;
                o_EX_ILLEGAL <= illegal;
            end else if (i_EX_READY) begin
                o_EX_VALID <= 1'b0;
            end
        end
    end

endmodule
